avalon_st_sample_sink: RTL and testbench
========================================

# avalon_st_sample_sink

Receiving end of the synthesizer's Avalon-ST sample stream. Accepts 32-bit sample words from the synthesizer's `aso_ss0` source with valid/ready backpressure and buffers them in a small FIFO. It releases one 24-bit signed sample per sample-rate tick toward a DAC or codec serializer. It also reports FIFO fill level and counts underruns so software can size the producer's batch rate.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in samples; power of two, 4..256.
- `LVL_W`, $clog2(DEPTH)+1: width of the level output.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `asi_snk0_data`  in  32: sample word. Bits [23:0] are the two's-complement sample; bits [31:24] are ignored.
- `asi_snk0_valid`  in  1: producer has a word on `asi_snk0_data`.
- `asi_snk0_ready`  out  1: sink can accept a word this cycle.
- `i_sample_tick`  in  1: one-`clk` strobe at the output sample rate (96 kHz).
- `o_sample`  out  24: signed output sample.
- `o_sample_valid`  out  1: one-cycle pulse when `o_sample` updates.
- `o_level`  out  LVL_W: current FIFO occupancy, 0..DEPTH.
- `o_underruns`  out  16: count of ticks that found the FIFO empty; saturating.

## Operation
- **Push:** a word is accepted on any cycle with `asi_snk0_valid && asi_snk0_ready`. `data[23:0]` is written at the write pointer.
- **Ready:** `asi_snk0_ready = (level != DEPTH)`. It is driven from registered state only, with no combinational path from `valid`. The producer may hold `valid` high indefinitely.
- **Pop:** on `i_sample_tick` with level > 0, the head is read, the read pointer advances, and `o_sample` is loaded.
- **Underrun:** on `i_sample_tick` with level == 0:
  - `o_underruns` increments, saturating at 16'hFFFF.
  - `o_sample` follows the Configuration rule.
  - `o_sample_valid` still pulses, because the DAC needs a sample every tick.
- **Push and pop in the same cycle:**
  - If the FIFO is non-empty, both happen and the level is unchanged.
  - If the FIFO is empty, there is no bypass: the pop is an underrun and the pushed word is stored.
- **Full:** `asi_snk0_ready` is low, so no push is possible. A tick in the same cycle pops, and `ready` rises the next cycle.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by an explicit count register; pointer comparison is not used.
- **Reset:** asserting `n_rst`, including mid-transfer, immediately clears the pointers, count, `o_sample`, `o_sample_valid` and `o_underruns`. FIFO contents are don't-care. Words in flight are dropped.

Reset values: `asi_snk0_ready`=0 while reset is asserted and 1 from the first cycle after release; `o_sample`=0; `o_sample_valid`=0; `o_level`=0; `o_underruns`=0.

## Timing
- Push to `o_level` increment: 1 cycle.
- Tick to `o_sample`/`o_sample_valid`: 1 cycle (registered output).
- A word accepted in cycle N is poppable by a tick in cycle N+1 or later.
- Ticks closer together than 2 cycles are not supported. Normal spacing is about 520 cycles at 50 MHz.
- Storage is registers or MLAB with synchronous write and asynchronous read. The output register provides the pipeline stage.

## Configuration
- **`SINK_UNDERRUN_HOLD_EN` defined:** on underrun, `o_sample` repeats the last successfully popped sample. This gives a click-free stall.
- **Not defined:** on underrun, `o_sample` is forced to 24'h000000 (silence).
- The counter and `o_sample_valid` behaviour are identical in both builds.

## Structure
- Shared package `synth_pkg`:
  - `SAMPLE_W = 24`
  - `ST_DATA_W = 32`
  - `typedef logic signed [SAMPLE_W-1:0] sample_t`
  - This package is reused by the mixer and the DAC path.
- Sub-module `sample_fifo`:
  - Parameterised on depth and width.
  - Ports: push/pop/full/empty/level.
  - The top instantiates it and adds the tick, output register and underrun logic.

## Test plan
- **Basic flow:** after reset, push 3 words 0x00000001, 0x00FFFFFF, 0x007FFFFF, then 3 ticks. Required: `o_sample` = 1, -1, 8388607, one per tick, each 1 cycle after its tick. `o_level` goes 3→0. `o_underruns`=0.
- **Fill:** hold `valid` high with DEPTH+4 distinct words and no ticks. Required: exactly 16 accepted, `ready`=0, `o_level`=16. One tick then gives `ready`=1 the next cycle and the 17th word is accepted.
- **Underrun:** pop the last sample 0x000123, then 3 ticks on an empty FIFO. Required: `o_underruns`=3 and `o_sample_valid` pulses 3 times. `o_sample`=0x000123 with `SINK_UNDERRUN_HOLD_EN`, or 0 without it.
- **Simultaneous:** push and tick in the same cycle.
  - With level 5: level stays 5 and the oldest sample is output.
  - With level 0: underrun increments, level becomes 1, and the next tick outputs the pushed word.
- **Wrap and reset:** stream 1000 incrementing samples at a random `valid` duty with a tick every 7 cycles. Required: the output order matches the input order. Then assert `n_rst` mid-stream. Required: all outputs are immediately at their reset values, and after release a new word is accepted on the first valid cycle.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared sample types for the synthesizer audio path (mixer, DAC path, sample sink).
package synth_pkg;
   localparam int SAMPLE_W  = 24;
   localparam int ST_DATA_W = 32;
   localparam int UNDERRUN_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Register-based FIFO: synchronous write, asynchronous read, occupancy tracked by an explicit count.
module sample_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 24,
   parameter int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == LVL_W'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage is not reset; only pointers and count carry state that matters.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/avalon_st_sample_sink.sv
// Avalon-ST sample sink: buffers 24-bit samples and releases one per sample tick.
// Build option SINK_UNDERRUN_HOLD_EN: repeat the last popped sample on underrun instead of silence.
module avalon_st_sample_sink
   import synth_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [ST_DATA_W-1:0] asi_snk0_data,
   input  logic                 asi_snk0_valid,
   output logic                 asi_snk0_ready,
   input  logic                 i_sample_tick,
   output logic [SAMPLE_W-1:0]  o_sample,
   output logic                 o_sample_valid,
   output logic [LVL_W-1:0]     o_level,
   output logic [15:0]          o_underruns
);
`ifdef SINK_UNDERRUN_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
      return (v == {UNDERRUN_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic                 rst_done;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [SAMPLE_W-1:0]  fifo_rd;
   logic                 push;
   logic                 pop;
   logic                 underrun;
   sample_t              sample_p1;
   logic                 vld_p1;
   logic [UNDERRUN_W-1:0] underruns;
   logic                 unused_hi;

   assign unused_hi      = ^asi_snk0_data[ST_DATA_W-1:SAMPLE_W];
   assign asi_snk0_ready = rst_done & ~fifo_full;
   assign push           = asi_snk0_valid & asi_snk0_ready;
   assign pop            = i_sample_tick & ~fifo_empty;
   assign underrun       = i_sample_tick & fifo_empty;

   sample_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (SAMPLE_W),
      .LVL_W  (LVL_W)
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push    (push),
      .wr_data (asi_snk0_data[SAMPLE_W-1:0]),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (o_level)
   );

   // Holds ready low during reset and releases it on the first clock afterwards.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) rst_done <= 1'b0;
      else        rst_done <= 1'b1;
   end

   // Stage p1: registered output sample, tick strobe and underrun counter
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sample_p1 <= '0;
         vld_p1    <= 1'b0;
         underruns <= '0;
      end else begin
         vld_p1 <= i_sample_tick;
         if (pop) begin
            sample_p1 <= sample_t'(fifo_rd);
         end else if (underrun) begin
            sample_p1 <= HOLD_EN ? sample_p1 : '0;
            underruns <= sat_inc(underruns);
         end
      end
   end

   assign o_sample       = sample_p1;
   assign o_sample_valid = vld_p1;
   assign o_underruns    = underruns;
endmodule

// File: tb/tb_avalon_st_sample_sink.sv
// Directed testbench for avalon_st_sample_sink (DEPTH=16).
module tb_avalon_st_sample_sink;
   localparam int DEPTH = 16;
   localparam int LVL_W = 5;
`ifdef SINK_UNDERRUN_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic [31:0]       asi_snk0_data = '0;
   logic              asi_snk0_valid = 1'b0;
   logic              asi_snk0_ready;
   logic              i_sample_tick = 1'b0;
   logic [23:0]       o_sample;
   logic              o_sample_valid;
   logic [LVL_W-1:0]  o_level;
   logic [15:0]       o_underruns;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   avalon_st_sample_sink #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .asi_snk0_data  (asi_snk0_data),
      .asi_snk0_valid (asi_snk0_valid),
      .asi_snk0_ready (asi_snk0_ready),
      .i_sample_tick  (i_sample_tick),
      .o_sample       (o_sample),
      .o_sample_valid (o_sample_valid),
      .o_level        (o_level),
      .o_underruns    (o_underruns)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      n_rst = 1'b0; asi_snk0_valid = 1'b0; i_sample_tick = 1'b0; asi_snk0_data = '0;
      step(); step();
      n_rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      n_rst = 1'b0; asi_snk0_valid = 1'b0; i_sample_tick = 1'b0;
      #2;
      n_checks++; if (asi_snk0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", asi_snk0_ready); end
      n_checks++; if (o_sample !== 24'h0) begin n_fail++; $display("FAIL rst_sample got=%h exp=0", o_sample); end
      n_checks++; if (o_sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", o_sample_valid); end
      n_checks++; if (o_level !== '0) begin n_fail++; $display("FAIL rst_level got=%0d exp=0", o_level); end
      n_checks++; if (o_underruns !== 16'h0) begin n_fail++; $display("FAIL rst_underruns got=%0d exp=0", o_underruns); end
      step();
      n_checks++; if (asi_snk0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_held got=%b exp=0", asi_snk0_ready); end
      n_rst = 1'b1;
      step();
      n_checks++; if (asi_snk0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_release got=%b exp=1", asi_snk0_ready); end
   endtask

   task automatic test_basic_flow();
      logic [31:0] words [3];
      logic [23:0] exps [3];
      words[0] = 32'h00000001; words[1] = 32'h00FFFFFF; words[2] = 32'h007FFFFF;
      exps[0]  = 24'h000001;   exps[1]  = 24'hFFFFFF;   exps[2]  = 24'h7FFFFF;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         asi_snk0_data = words[i]; asi_snk0_valid = 1'b1;
         step();
         asi_snk0_valid = 1'b0;
         n_checks++; if (o_level !== LVL_W'(i + 1)) begin n_fail++; $display("FAIL basic_level_push%0d got=%0d exp=%0d", i, o_level, i + 1); end
      end
      for (int i = 0; i < 3; i++) begin
         i_sample_tick = 1'b1;
         step();
         i_sample_tick = 1'b0;
         n_checks++; if (o_sample_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid%0d got=%b exp=1", i, o_sample_valid); end
         n_checks++; if (o_sample !== exps[i]) begin n_fail++; $display("FAIL basic_sample%0d got=%h exp=%h", i, o_sample, exps[i]); end
         n_checks++; if (o_level !== LVL_W'(2 - i)) begin n_fail++; $display("FAIL basic_level_pop%0d got=%0d exp=%0d", i, o_level, 2 - i); end
         step();
         n_checks++; if (o_sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop%0d got=%b exp=0", i, o_sample_valid); end
      end
      n_checks++; if (o_underruns !== 16'd0) begin n_fail++; $display("FAIL basic_underruns got=%0d exp=0", o_underruns); end
   endtask

   task automatic test_fill();
      int idx = 0;
      int acc = 0;
      logic was_ready;
      apply_reset();
      for (int c = 0; c < DEPTH + 4; c++) begin
         asi_snk0_data = {8'hA5, 24'h000100 + 24'(idx)};
         asi_snk0_valid = 1'b1;
         was_ready = asi_snk0_ready;
         step();
         if (was_ready) begin acc++; idx++; end
      end
      n_checks++; if (acc !== DEPTH) begin n_fail++; $display("FAIL fill_accepted got=%0d exp=%0d", acc, DEPTH); end
      n_checks++; if (asi_snk0_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full got=%b exp=0", asi_snk0_ready); end
      n_checks++; if (o_level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL fill_level got=%0d exp=%0d", o_level, DEPTH); end
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      n_checks++; if (asi_snk0_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after_tick got=%b exp=1", asi_snk0_ready); end
      n_checks++; if (o_level !== LVL_W'(DEPTH - 1)) begin n_fail++; $display("FAIL fill_level_after_tick got=%0d exp=%0d", o_level, DEPTH - 1); end
      n_checks++; if (o_sample !== 24'h000100) begin n_fail++; $display("FAIL fill_first_out got=%h exp=000100", o_sample); end
      step();
      asi_snk0_valid = 1'b0;
      n_checks++; if (o_level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL fill_17th_level got=%0d exp=%0d", o_level, DEPTH); end
      n_checks++; if (asi_snk0_ready !== 1'b0) begin n_fail++; $display("FAIL fill_17th_ready got=%b exp=0", asi_snk0_ready); end
      for (int k = 1; k <= DEPTH; k++) begin
         i_sample_tick = 1'b1;
         step();
         i_sample_tick = 1'b0;
         n_checks++; if (o_sample !== 24'h000100 + 24'(k)) begin n_fail++; $display("FAIL fill_drain%0d got=%h exp=%h", k, o_sample, 24'h000100 + 24'(k)); end
         step();
      end
      n_checks++; if (o_level !== '0) begin n_fail++; $display("FAIL fill_drained_level got=%0d exp=0", o_level); end
   endtask

   task automatic test_underrun();
      logic [23:0] exp_s;
      exp_s = HOLD ? 24'h000123 : 24'h000000;
      apply_reset();
      asi_snk0_data = 32'h00000123; asi_snk0_valid = 1'b1;
      step();
      asi_snk0_valid = 1'b0;
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      n_checks++; if (o_sample !== 24'h000123) begin n_fail++; $display("FAIL urun_last got=%h exp=000123", o_sample); end
      step();
      for (int i = 0; i < 3; i++) begin
         i_sample_tick = 1'b1;
         step();
         i_sample_tick = 1'b0;
         n_checks++; if (o_sample_valid !== 1'b1) begin n_fail++; $display("FAIL urun_valid%0d got=%b exp=1", i, o_sample_valid); end
         n_checks++; if (o_sample !== exp_s) begin n_fail++; $display("FAIL urun_sample%0d got=%h exp=%h", i, o_sample, exp_s); end
         step();
         n_checks++; if (o_sample_valid !== 1'b0) begin n_fail++; $display("FAIL urun_valid_drop%0d got=%b exp=0", i, o_sample_valid); end
      end
      n_checks++; if (o_underruns !== 16'd3) begin n_fail++; $display("FAIL urun_count got=%0d exp=3", o_underruns); end
   endtask

   task automatic test_simultaneous();
      logic [23:0] exp_s;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         asi_snk0_data = 32'h00000200 + 32'(i); asi_snk0_valid = 1'b1;
         step();
      end
      asi_snk0_data = 32'h00000205; i_sample_tick = 1'b1;
      step();
      asi_snk0_valid = 1'b0; i_sample_tick = 1'b0;
      n_checks++; if (o_level !== LVL_W'(5)) begin n_fail++; $display("FAIL simul_level5 got=%0d exp=5", o_level); end
      n_checks++; if (o_sample !== 24'h000200) begin n_fail++; $display("FAIL simul_oldest got=%h exp=000200", o_sample); end
      step();
      for (int k = 1; k <= 5; k++) begin
         i_sample_tick = 1'b1;
         step();
         i_sample_tick = 1'b0;
         n_checks++; if (o_sample !== 24'h000200 + 24'(k)) begin n_fail++; $display("FAIL simul_drain%0d got=%h exp=%h", k, o_sample, 24'h000200 + 24'(k)); end
         step();
      end
      asi_snk0_data = 32'h00000300; asi_snk0_valid = 1'b1; i_sample_tick = 1'b1;
      step();
      asi_snk0_valid = 1'b0; i_sample_tick = 1'b0;
      exp_s = HOLD ? 24'h000205 : 24'h000000;
      n_checks++; if (o_underruns !== 16'd1) begin n_fail++; $display("FAIL simul_empty_underruns got=%0d exp=1", o_underruns); end
      n_checks++; if (o_level !== LVL_W'(1)) begin n_fail++; $display("FAIL simul_empty_level got=%0d exp=1", o_level); end
      n_checks++; if (o_sample !== exp_s) begin n_fail++; $display("FAIL simul_empty_sample got=%h exp=%h", o_sample, exp_s); end
      step();
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      n_checks++; if (o_sample !== 24'h000300) begin n_fail++; $display("FAIL simul_pushed_out got=%h exp=000300", o_sample); end
      n_checks++; if (o_underruns !== 16'd1) begin n_fail++; $display("FAIL simul_underruns_after got=%0d exp=1", o_underruns); end
      step();
   endtask

   task automatic test_wrap_reset();
      logic [23:0] q [$];
      logic [23:0] last_pop = '0;
      logic [23:0] exp_s;
      int sent = 0;
      int pops = 0;
      int cyc = 0;
      logic v_now, t_now, acc, exp_pop;
      apply_reset();
      while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
         v_now = (sent < 1000) && ($urandom_range(0, 99) < 60);
         t_now = ((cyc % 7) == 6);
         asi_snk0_data = 32'(sent); asi_snk0_valid = v_now; i_sample_tick = t_now;
         acc = v_now && asi_snk0_ready;
         exp_pop = t_now && (q.size() > 0);
         exp_s = HOLD ? last_pop : 24'h0;
         if (exp_pop) exp_s = q.pop_front();
         step();
         if (acc) begin q.push_back(24'(sent)); sent++; end
         if (t_now) begin
            n_checks++; if (o_sample_valid !== 1'b1 || o_sample !== exp_s) begin n_fail++; $display("FAIL wrap_out cyc=%0d got=%h/%b exp=%h/1", cyc, o_sample, o_sample_valid, exp_s); end
            if (exp_pop) begin last_pop = exp_s; pops++; end
         end
         cyc++;
      end
      asi_snk0_valid = 1'b0; i_sample_tick = 1'b0;
      n_checks++; if (pops !== 1000) begin n_fail++; $display("FAIL wrap_popcount got=%0d exp=1000 (cycles=%0d)", pops, cyc); end
      for (int i = 0; i < 3; i++) begin
         asi_snk0_data = 32'h00000AA0 + 32'(i); asi_snk0_valid = 1'b1;
         step();
      end
      #2;
      n_rst = 1'b0;
      #1;
      n_checks++; if (asi_snk0_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", asi_snk0_ready); end
      n_checks++; if (o_level !== '0) begin n_fail++; $display("FAIL midrst_level got=%0d exp=0", o_level); end
      n_checks++; if (o_sample !== 24'h0) begin n_fail++; $display("FAIL midrst_sample got=%h exp=0", o_sample); end
      n_checks++; if (o_sample_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", o_sample_valid); end
      n_checks++; if (o_underruns !== 16'h0) begin n_fail++; $display("FAIL midrst_underruns got=%0d exp=0", o_underruns); end
      asi_snk0_data = 32'h00000555;
      step();
      n_rst = 1'b1;
      step();
      n_checks++; if (asi_snk0_ready !== 1'b1) begin n_fail++; $display("FAIL postrst_ready got=%b exp=1", asi_snk0_ready); end
      n_checks++; if (o_level !== '0) begin n_fail++; $display("FAIL postrst_level0 got=%0d exp=0", o_level); end
      step();
      asi_snk0_valid = 1'b0;
      n_checks++; if (o_level !== LVL_W'(1)) begin n_fail++; $display("FAIL postrst_level1 got=%0d exp=1", o_level); end
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      n_checks++; if (o_sample !== 24'h000555) begin n_fail++; $display("FAIL postrst_sample got=%h exp=000555", o_sample); end
      step();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_flow();
      test_fill();
      test_underrun();
      test_simultaneous();
      test_wrap_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
